// File: rtl/rw_burst_mem_responder_pkg.sv
// Shared encodings for the rw bus responder: transfer sizes, burst types, FSM states.
// Also carries the size clamp used by both the address stepper and the lane masks.
package rw_burst_mem_responder_pkg;

    localparam logic [2:0] AXI_SIZE_BYTES_1 = 3'd0;
    localparam logic [2:0] AXI_SIZE_BYTES_2 = 3'd1;
    localparam logic [2:0] AXI_SIZE_BYTES_4 = 3'd2;
    localparam logic [2:0] AXI_SIZE_BYTES_8 = 3'd3;

    localparam logic [1:0] AXI_BURST_TYPE_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_TYPE_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_TYPE_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RLAT = 2'd2,
        S_RD   = 2'd3
    } state_t;

    // Sizes wider than the 64-bit bus behave as full-word beats.
    function automatic logic [2:0] eff_size(input logic [2:0] size);
        return size[2] ? AXI_SIZE_BYTES_8 : size;
    endfunction

endpackage

// File: rtl/rw_lane_mask.sv
// Byte strobe and read mask for one beat of a given size at a given byte lane.
// Strobe bits shifted past lane 7 fall off, so a beat never spills into the next word.
module rw_lane_mask
    import rw_burst_mem_responder_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [2:0]  lane,
    output logic [7:0]  strb,
    output logic [63:0] rmask
);

    logic [7:0] base;

    always_comb begin
        base = 8'h00;
        unique case (eff_size(size))
            AXI_SIZE_BYTES_1: base = 8'h01;
            AXI_SIZE_BYTES_2: base = 8'h03;
            AXI_SIZE_BYTES_4: base = 8'h0f;
            AXI_SIZE_BYTES_8: base = 8'hff;
            default:          base = 8'hff;
        endcase
    end

    always_comb begin
        strb  = base << lane;
        rmask = '0;
        for (int b = 0; b < 8; b++) begin
            rmask[b*8 +: 8] = {8{base[b]}};
        end
    end

endmodule

// File: rtl/rw_burst_mem_responder.sv
// Responder for the rw bus: single/burst reads and writes into a 64-bit word array,
// with a programmable delay from read request to first data beat.
module rw_burst_mem_responder
    import rw_burst_mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_AW     = 12,
    parameter int RD_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rw_addr_valid_i,
    output logic                  rw_addr_ready_o,
    input  logic [ADDR_WIDTH-1:0] rw_addr_i,
    input  logic                  rw_we_i,
    input  logic [7:0]            rw_len_i,
    input  logic [2:0]            rw_size_i,
    input  logic [1:0]            rw_burst_i,
    input  logic                  rw_if_i,
    input  logic                  w_data_valid_i,
    output logic                  w_data_ready_o,
    input  logic [DATA_WIDTH-1:0] w_data_i,
    output logic                  r_data_valid_o,
    input  logic                  r_data_ready_i,
    output logic [DATA_WIDTH-1:0] r_data_o
);

    logic [DATA_WIDTH-1:0] mem [2**MEM_AW];

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [7:0]            cnt;
    logic [3:0]            lat;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  fetch_tag;
    logic                  unused_ok;

    logic [7:0]            strb;
    logic [63:0]           rmask;
    logic [MEM_AW-1:0]     wr_word;
    logic [MEM_AW-1:0]     rd_word;
    logic [5:0]            wr_shift;
    logic [5:0]            rd_shift;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_fire;

    // The tag is kept for debug visibility only.
    assign unused_ok = fetch_tag;

    rw_lane_mask u_lane_mask (
        .size  (size),
        .lane  (addr[2:0]),
        .strb  (strb),
        .rmask (rmask)
    );

    // In RD the next beat is fetched from the stepped address so it is ready on handshake.
    always_comb begin
        next_addr = addr;
        if (burst != AXI_BURST_TYPE_FIXED) begin
            next_addr = addr + (ADDR_WIDTH'(1) << eff_size(size));
        end
        rd_addr  = (state == S_RD) ? next_addr : addr;
        wr_word  = addr[MEM_AW+2:3];
        rd_word  = rd_addr[MEM_AW+2:3];
        wr_shift = {addr[2:0], 3'b000};
        rd_shift = {rd_addr[2:0], 3'b000};
        wr_data  = w_data_i << wr_shift;
        rd_data  = (mem[rd_word] >> rd_shift) & rmask;
    end

    assign wr_fire = !rst && state == S_WR && w_data_valid_i && w_data_ready_o;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int b = 0; b < 8; b++) begin
                if (strb[b]) begin
                    mem[wr_word][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            rw_addr_ready_o <= 1'b1;
            w_data_ready_o  <= 1'b0;
            r_data_valid_o  <= 1'b0;
            r_data_o        <= '0;
            addr            <= '0;
            cnt             <= '0;
            lat             <= '0;
            size            <= '0;
            burst           <= '0;
            fetch_tag       <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (rw_addr_valid_i && rw_addr_ready_o) begin
                        addr            <= rw_addr_i;
                        cnt             <= rw_len_i;
                        size            <= rw_size_i;
                        burst           <= rw_burst_i;
                        fetch_tag       <= rw_if_i;
                        rw_addr_ready_o <= 1'b0;
                        if (rw_we_i) begin
                            state          <= S_WR;
                            w_data_ready_o <= 1'b1;
                        end else begin
                            state <= S_RLAT;
                            lat   <= 4'(RD_LAT - 1);
                        end
                    end
                end
                S_WR: begin
                    if (w_data_valid_i) begin
                        addr <= next_addr;
                        if (cnt == 8'd0) begin
                            state           <= S_IDLE;
                            w_data_ready_o  <= 1'b0;
                            rw_addr_ready_o <= 1'b1;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                end
                S_RLAT: begin
                    if (lat == 4'd0) begin
                        r_data_o       <= rd_data;
                        r_data_valid_o <= 1'b1;
                        state          <= S_RD;
                    end else begin
                        lat <= lat - 4'd1;
                    end
                end
                S_RD: begin
                    if (r_data_ready_i) begin
                        if (cnt == 8'd0) begin
                            r_data_valid_o  <= 1'b0;
                            rw_addr_ready_o <= 1'b1;
                            state           <= S_IDLE;
                        end else begin
                            cnt      <= cnt - 8'd1;
                            addr     <= next_addr;
                            r_data_o <= rd_data;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
